// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the RAM burst master.
package ram_burst_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_LEN_WIDTH  = 4;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WR         = 3'd1,
      RD_ISSUE   = 3'd2,
      RD_CAPTURE = 3'd3,
      RD_RESP    = 3'd4
   } state_t;

endpackage

// File: rtl/ram_burst_master.sv
// Burst master for a single-port synchronous RAM: fill-write bursts and read bursts
// with a valid/ready response channel. Every output is a register.
module ram_burst_master
   import ram_burst_pkg::*;
#(
   parameter int N          = 256,
   parameter int ADDR_WIDTH = $clog2(N),
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  ram_enable,
   output logic                  ram_read_write,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_last,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(N - 1);

   // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
   // a read beat transfers on a rising edge where rsp_valid && rsp_ready.
   state_t                state;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  beat;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  is_last;

   // Wrap explicitly so non-power-of-two depths stay inside the RAM.
   assign addr_next = (ram_addr == ADDR_MAX) ? '0 : ram_addr + ADDR_WIDTH'(1);
   assign is_last   = (beat == len_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         req_ready      <= 1'b0;
         ram_enable     <= 1'b0;
         ram_read_write <= 1'b0;
         ram_addr       <= '0;
         ram_data_in    <= '0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_last       <= 1'b0;
         done           <= 1'b0;
         len_q          <= '0;
         beat           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               req_ready      <= 1'b1;
               ram_enable     <= 1'b0;
               ram_read_write <= 1'b0;
               if (req_valid && req_ready) begin
                  // ram_addr and ram_data_in double as the latched request fields.
                  req_ready      <= 1'b0;
                  ram_enable     <= 1'b1;
                  ram_read_write <= req_write;
                  ram_addr       <= req_addr;
                  ram_data_in    <= req_wdata;
                  len_q          <= req_len;
                  beat           <= '0;
                  state          <= req_write ? WR : RD_ISSUE;
               end
            end
            WR: begin
               if (is_last) begin
                  ram_enable     <= 1'b0;
                  ram_read_write <= 1'b0;
                  done           <= 1'b1;
                  req_ready      <= 1'b1;
                  state          <= IDLE;
               end else begin
                  beat     <= beat + LEN_WIDTH'(1);
                  ram_addr <= addr_next;
               end
            end
            RD_ISSUE: begin
               ram_enable <= 1'b0;
               state      <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               rsp_rdata <= ram_data_out;
               rsp_valid <= 1'b1;
               rsp_last  <= is_last;
               state     <= RD_RESP;
            end
            RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  if (is_last) begin
                     done      <= 1'b1;
                     req_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     beat       <= beat + LEN_WIDTH'(1);
                     ram_addr   <= addr_next;
                     ram_enable <= 1'b1;
                     state      <= RD_ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 256x32 RAM beside it.
module tb_ram_burst_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [3:0]  req_len;
   logic [31:0] req_wdata;
   logic        ram_enable;
   logic        ram_read_write;
   logic [7:0]  ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_last;
   logic        done;

   logic [31:0] mem [256];
   logic        preload;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ram_burst_master dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_len        (req_len),
      .req_wdata      (req_wdata),
      .ram_enable     (ram_enable),
      .ram_read_write (ram_read_write),
      .ram_addr       (ram_addr),
      .ram_data_in    (ram_data_in),
      .ram_data_out   (ram_data_out),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_last       (rsp_last),
      .done           (done)
   );

   // Word i starts as 0x1000_0000 + i so untouched locations are recognisable.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
      end else if (ram_enable) begin
         if (ram_read_write) mem[ram_addr] <= ram_data_in;
         else                ram_data_out <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the first burst cycle.
   task automatic issue(input logic wr, input logic [7:0] a, input logic [3:0] l,
                        input logic [31:0] d);
      int waited = 0;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_len   = l;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int done_cnt;
      reset = 1'b0; preload = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_len = '0; req_wdata = '0; rsp_ready = 1'b0;
      @(negedge clk);
      preload = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_ram_enable", {31'd0, ram_enable}, 32'd0);
      check("rst_ram_rw", {31'd0, ram_read_write}, 32'd0);
      check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      check("rst_ram_data_in", ram_data_in, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {31'd0, req_ready}, 32'd1);

      // Fill write 0x10..0x13
      issue(1'b1, 8'h10, 4'd3, 32'hA5A5_A5A5);
      for (int i = 0; i < 4; i++) begin
         check("wr_enable", {31'd0, ram_enable}, 32'd1);
         check("wr_rw", {31'd0, ram_read_write}, 32'd1);
         check("wr_addr", {24'd0, ram_addr}, 32'h10 + i);
         check("wr_data", ram_data_in, 32'hA5A5_A5A5);
         check("wr_done_early", {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      check("wr_done", {31'd0, done}, 32'd1);
      check("wr_enable_off", {31'd0, ram_enable}, 32'd0);
      @(negedge clk);
      check("wr_done_pulse", {31'd0, done}, 32'd0);
      for (int i = 0; i < 4; i++) check("wr_mem", mem[8'h10 + i], 32'hA5A5_A5A5);
      check("wr_mem_beyond", mem[8'h14], 32'h1000_0014);

      // Read 0x10..0x13 with the consumer always ready: a beat every 3 cycles
      rsp_ready = 1'b1;
      issue(1'b0, 8'h10, 4'd3, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (done) done_cnt++;
         check("rd_enable", {31'd0, ram_enable}, (i % 3 == 0 && i < 12) ? 32'd1 : 32'd0);
         if (i % 3 == 0 && i < 12) begin
            check("rd_rw", {31'd0, ram_read_write}, 32'd0);
            check("rd_addr", {24'd0, ram_addr}, 32'h10 + i / 3);
         end
         check("rd_valid", {31'd0, rsp_valid}, (i % 3 == 2 && i < 12) ? 32'd1 : 32'd0);
         if (i % 3 == 2 && i < 12) begin
            check("rd_data", rsp_rdata, 32'hA5A5_A5A5);
            check("rd_last", {31'd0, rsp_last}, (i == 11) ? 32'd1 : 32'd0);
         end
         if (i == 12) check("rd_done", {31'd0, done}, 32'd1);
         @(negedge clk);
      end
      check("rd_done_count", done_cnt, 32'd1);

      // Write that wraps past the top address
      issue(1'b1, 8'hFE, 4'd2, 32'h5A5A_5A5A);
      check("wrap_addr0", {24'd0, ram_addr}, 32'hFE);
      @(negedge clk);
      check("wrap_addr1", {24'd0, ram_addr}, 32'hFF);
      @(negedge clk);
      check("wrap_addr2", {24'd0, ram_addr}, 32'h00);
      @(negedge clk);
      check("wrap_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("wrap_mem_fe", mem[8'hFE], 32'h5A5A_5A5A);
      check("wrap_mem_ff", mem[8'hFF], 32'h5A5A_5A5A);
      check("wrap_mem_00", mem[8'h00], 32'h5A5A_5A5A);
      check("wrap_mem_01", mem[8'h01], 32'h1000_0001);

      // Read with the consumer stalled for 5 cycles on the first beat
      rsp_ready = 1'b0;
      issue(1'b0, 8'h13, 4'd1, 32'd0);
      check("stall_issue", {31'd0, ram_enable}, 32'd1);
      @(negedge clk);
      check("stall_capture_en", {31'd0, ram_enable}, 32'd0);
      check("stall_capture_valid", {31'd0, rsp_valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, rsp_valid}, 32'd1);
         check("stall_data", rsp_rdata, 32'hA5A5_A5A5);
         check("stall_last", {31'd0, rsp_last}, 32'd0);
         check("stall_enable", {31'd0, ram_enable}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_beat1_en", {31'd0, ram_enable}, 32'd1);
      check("stall_beat1_addr", {24'd0, ram_addr}, 32'h14);
      check("stall_beat1_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      check("stall_beat1_vld", {31'd0, rsp_valid}, 32'd1);
      check("stall_beat1_data", rsp_rdata, 32'h1000_0014);
      check("stall_beat1_last", {31'd0, rsp_last}, 32'd1);
      @(negedge clk);
      check("stall_done", {31'd0, done}, 32'd1);
      check("stall_valid_drop", {31'd0, rsp_valid}, 32'd0);

      // Reset in the middle of a 16-beat write, just before beat 4
      issue(1'b1, 8'h40, 4'd15, 32'hCAFE_F00D);
      repeat (3) @(negedge clk);
      check("abort_beat3_addr", {24'd0, ram_addr}, 32'h43);
      reset = 1'b0;
      @(negedge clk);
      check("abort_enable", {31'd0, ram_enable}, 32'd0);
      check("abort_rw", {31'd0, ram_read_write}, 32'd0);
      check("abort_addr", {24'd0, ram_addr}, 32'd0);
      check("abort_data_in", ram_data_in, 32'd0);
      check("abort_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("abort_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ready_after", {31'd0, req_ready}, 32'd1);
      check("abort_enable_after", {31'd0, ram_enable}, 32'd0);
      check("abort_done_after", {31'd0, done}, 32'd0);
      check("abort_mem_43", mem[8'h43], 32'hCAFE_F00D);
      check("abort_mem_44", mem[8'h44], 32'h1000_0044);
      check("abort_mem_4f", mem[8'h4F], 32'h1000_004F);

      // req_valid held high: the second request waits for IDLE
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_len = 4'd1;
      req_wdata = 32'h1111_1111;
      @(negedge clk);
      req_addr = 8'h90; req_wdata = 32'h2222_2222;
      check("hold_ready0", {31'd0, req_ready}, 32'd0);
      check("hold_addr0", {24'd0, ram_addr}, 32'h80);
      check("hold_data0", ram_data_in, 32'h1111_1111);
      @(negedge clk);
      check("hold_ready1", {31'd0, req_ready}, 32'd0);
      check("hold_addr1", {24'd0, ram_addr}, 32'h81);
      check("hold_data1", ram_data_in, 32'h1111_1111);
      @(negedge clk);
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_ready_idle", {31'd0, req_ready}, 32'd1);
      check("hold_enable_idle", {31'd0, ram_enable}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("hold2_enable", {31'd0, ram_enable}, 32'd1);
      check("hold2_addr", {24'd0, ram_addr}, 32'h90);
      check("hold2_data", ram_data_in, 32'h2222_2222);
      check("hold2_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("hold2_addr1", {24'd0, ram_addr}, 32'h91);
      @(negedge clk);
      check("hold2_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("hold_mem_80", mem[8'h80], 32'h1111_1111);
      check("hold_mem_81", mem[8'h81], 32'h1111_1111);
      check("hold_mem_90", mem[8'h90], 32'h2222_2222);
      check("hold_mem_91", mem[8'h91], 32'h2222_2222);
      check("hold_mem_82", mem[8'h82], 32'h1000_0082);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have parameter N, default 256, meaning RAM depth in words.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(N), meaning RAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning RAM word width.
REQ-004 SHALL have parameter LEN_WIDTH, default 4, meaning burst length field width (beats = len+1).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit, request offered.
REQ-008 SHALL have port req_ready, output, 1 bit, request accepted when high with req_valid.
REQ-009 SHALL have port req_write, input, 1 bit, 1 = fill-write burst, 0 = read burst.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH bits, start address.
REQ-011 SHALL have port req_len, input, LEN_WIDTH bits, beats minus one.
REQ-012 SHALL have port req_wdata, input, DATA_WIDTH bits, fill value for write bursts.
REQ-013 SHALL have port ram_enable, output, 1 bit, drives the RAM enable.
REQ-014 SHALL have port ram_read_write, output, 1 bit, drives the RAM read_write (1 = write).
REQ-015 SHALL have port ram_addr, output, ADDR_WIDTH bits, drives the RAM addr.
REQ-016 SHALL have port ram_data_in, output, DATA_WIDTH bits, drives the RAM data_in.
REQ-017 SHALL have port ram_data_out, input, DATA_WIDTH bits, from RAM data_out, valid one cycle after a read enable.
REQ-018 SHALL have port rsp_valid, output, 1 bit, read beat available.
REQ-019 SHALL have port rsp_ready, input, 1 bit, consumer accepts the beat.
REQ-020 SHALL have port rsp_rdata, output, DATA_WIDTH bits, read beat data.
REQ-021 SHALL have port rsp_last, output, 1 bit, marks the final read beat.
REQ-022 SHALL have port done, output, 1 bit, one-cycle pulse when a burst completes.

Function
REQ-023 SHALL implement FSM states IDLE, WR, RD_ISSUE, RD_CAPTURE, RD_RESP.
REQ-024 SHALL register all outputs and assert req_ready only in IDLE.
REQ-025 SHALL, on req_valid && req_ready at edge k, latch write, addr, len and wdata, then enter WR or RD_ISSUE.
REQ-026 SHALL hold req_ready low and ignore req_valid in every non-IDLE state.
REQ-027 WR SHALL drive ram_enable=1, ram_read_write=1, ram_data_in=latched wdata for len+1 consecutive cycles starting at cycle k+1, with ram_addr incrementing by 1 each beat.
REQ-028 RD_ISSUE SHALL drive ram_enable=1 and ram_read_write=0 for exactly one cycle per beat.
REQ-029 RD_CAPTURE SHALL keep ram_enable=0 and load ram_data_out into rsp_rdata at its end.
REQ-030 RD_RESP SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_last until rsp_ready, then go to RD_ISSUE for the next beat, or to IDLE after the last beat.
REQ-031 First read response SHALL be visible at cycle k+3 at the earliest (issue k+1, capture k+2).
REQ-032 Address arithmetic SHALL be modulo N: N-1 wraps to 0.
REQ-033 rsp_last SHALL be 1 only on beat index len.
REQ-034 done SHALL pulse for one cycle in the cycle after the final write beat, or in the cycle after the final read beat handshake.
REQ-035 ram_enable SHALL be 0 in IDLE, RD_CAPTURE and RD_RESP.
REQ-036 len=0 SHALL produce exactly one beat.

Reset
REQ-037 reset low at a rising edge SHALL force IDLE and drive req_ready, ram_enable, ram_read_write, rsp_valid, rsp_last and done to 0, and ram_addr, ram_data_in and rsp_rdata to 0.
REQ-038 Reset mid-burst SHALL abort the burst with no further RAM access and no done pulse.
REQ-039 req_ready SHALL rise in the first cycle after reset is released.

Structure
REQ-040 Package ram_burst_pkg SHALL hold the FSM state enum and the default DATA_WIDTH and LEN_WIDTH constants.
REQ-041 The block SHALL contain no sub-modules; the existing ram SHALL be instanced beside it only in the bench.

Verification
REQ-042 Fill write addr=0x10, len=3, wdata=0xA5A5A5A5 -> memory[0x10..0x13]=0xA5A5A5A5, memory[0x14] unchanged, done one cycle.
REQ-043 Read addr=0x10, len=3, rsp_ready=1 -> four beats of 0xA5A5A5A5, rsp_last on the 4th, done once.
REQ-044 Write addr=0xFE, len=2, wdata=0x5A5A5A5A -> memory[0xFE], [0xFF] and [0x00] are written.
REQ-045 Read with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, ram_enable stays 0.
REQ-046 reset low mid-write of len=15 at beat 4 -> memory beyond beat 3 untouched, outputs 0, req_ready=1 the cycle after release.
REQ-047 req_valid held high during a burst -> second request accepted only once IDLE is reached.
